// File: rtl/cordic_pkg.sv
// Shared types and fixed-point constants for the CORDIC request scheduler.
// Operands are signed fixed point with 15 fraction bits.
package cordic_pkg;

    localparam int W_DEF = 32;
    localparam int Q_ONE = 32768;
    localparam int PI_Q  = 102944;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_RESP
    } state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// Request and response channels between the requesters and the CORDIC scheduler.
// Requester i occupies bits [i*W +: W] of each packed operand bus.
interface cordic_sched_if
    import cordic_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_DEF
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_mode;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ*W-1:0] req_z;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;
    logic [W-1:0]      rsp_x;
    logic [W-1:0]      rsp_y;
    logic [W-1:0]      rsp_z;

    modport slave (
        input  req_valid, req_mode, req_x, req_y, req_z, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z
    );

    modport master (
        output req_valid, req_mode, req_x, req_y, req_z, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z
    );

endinterface

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr upward,
// with ptr moving to one past the winner whenever a grant is taken.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] cand;
    logic           found;

    // NOTE: every variable is given a default before the loop so an empty request vector cannot infer a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = cand;
            end
        end
    end

    assign ptr_d = IDW'(wrap_inc(int'(idx_o), NREQ));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative CORDIC core among NREQ requesters: round-robin grant,
// start/done sequencing, watchdog abort and an ID-tagged response channel.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_sched_if.slave        bus,
    output logic                 cor_start,
    output logic                 cor_mode,
    output logic [W-1:0]         cor_x,
    output logic [W-1:0]         cor_y,
    output logic [W-1:0]         cor_z,
    output logic                 cor_rst,
    input  logic                 cor_done,
    input  logic [W-1:0]         cor_xo,
    input  logic [W-1:0]         cor_yo,
    input  logic [W-1:0]         cor_zo
);

    localparam int WDW = $clog2(TIMEOUT);

    state_e          state_q;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] req_ready;
    logic [IDW-1:0]  grant_idx;
    logic            accept;
    logic [W-1:0]    sel_x, sel_y, sel_z;

    logic [IDW-1:0]  id_q;
    logic            mode_q, start_q, abort_q;
    logic [W-1:0]    op_x_q, op_y_q, op_z_q;
    logic [WDW-1:0]  wd_q;
    logic            rsp_valid_q, rsp_err_q;
    logic [W-1:0]    rsp_x_q, rsp_y_q, rsp_z_q;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req_valid),
        .advance_i (accept),
        .grant_o   (grant),
        .idx_o     (grant_idx)
    );

    // Grants are only offered in IDLE, so the response handshake cycle never overlaps a new accept.
    assign req_ready     = (state_q == S_IDLE && !rst) ? grant : '0;
    assign accept        = |req_ready;
    assign bus.req_ready = req_ready;

    assign sel_x = bus.req_x[int'(grant_idx)*W +: W];
    assign sel_y = bus.req_y[int'(grant_idx)*W +: W];
    assign sel_z = bus.req_z[int'(grant_idx)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            mode_q      <= 1'b0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            op_z_q      <= '0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_z_q     <= '0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        id_q    <= grant_idx;
                        mode_q  <= bus.req_mode[grant_idx];
                        op_x_q  <= sel_x;
                        op_y_q  <= sel_y;
                        op_z_q  <= sel_z;
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    wd_q    <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (cor_done) begin
                        rsp_x_q     <= cor_xo;
                        rsp_y_q     <= cor_yo;
                        rsp_z_q     <= cor_zo;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        rsp_x_q     <= '0;
                        rsp_y_q     <= '0;
                        rsp_z_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        abort_q     <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cor_start     = start_q;
    assign cor_mode      = mode_q;
    assign cor_x         = op_x_q;
    assign cor_y         = op_y_q;
    assign cor_z         = op_z_q;
    assign cor_rst       = rst | abort_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_x     = rsp_x_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a behavioural real-math CORDIC core
// and a scoreboard of expected responses pushed at each accepted request.
module tb_cordic_sched;
    import cordic_pkg::*;

    localparam int  NREQ    = 2;
    localparam int  W       = 32;
    localparam int  TIMEOUT = 64;
    localparam int  LAT     = 8;
    localparam real KG      = 1.6467602581210654;

    typedef struct {
        int   id;
        logic err;
        int   x, y, z;
        int   tx, ty, tz;
    } exp_t;

    typedef struct packed {
        logic signed [W-1:0] x, y, z;
    } trip_t;

    logic         clk;
    logic         rst;
    logic         cor_start, cor_mode, cor_rst, cor_done;
    logic [W-1:0] cor_x, cor_y, cor_z, cor_xo, cor_yo, cor_zo;

    cordic_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    cordic_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cor_start (cor_start),
        .cor_mode  (cor_mode),
        .cor_x     (cor_x),
        .cor_y     (cor_y),
        .cor_z     (cor_z),
        .cor_rst   (cor_rst),
        .cor_done  (cor_done),
        .cor_xo    (cor_xo),
        .cor_yo    (cor_yo),
        .cor_zo    (cor_zo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t sb[$];

    // ---------------- behavioural core ----------------
    logic  kill_done = 1'b0;
    logic  core_busy;
    int    core_cnt;
    trip_t pend;

    function automatic trip_t core_calc(input logic m, input logic signed [W-1:0] x, y, z);
        real   rx, ry, a, o1, o2, o3;
        trip_t t;
        rx = $itor(x);
        ry = $itor(y);
        a  = $itor(z) / 32768.0;
        if (!m) begin
            if (x == 0 && y == 0) begin
                o1 = 32768.0 * $cos(a);
                o2 = 32768.0 * $sin(a);
            end else begin
                o1 = KG * (rx * $cos(a) - ry * $sin(a));
                o2 = KG * (ry * $cos(a) + rx * $sin(a));
            end
            o3 = 0.0;
        end else begin
            o1 = KG * $sqrt(rx * rx + ry * ry);
            o2 = 0.0;
            o3 = $itor(z) + 32768.0 * $atan2(ry, rx);
        end
        t.x = $rtoi(o1);
        t.y = $rtoi(o2);
        t.z = $rtoi(o3);
        return t;
    endfunction

    always @(posedge clk) begin
        cor_done <= 1'b0;
        if (cor_rst) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
        end else if (cor_start) begin
            core_busy <= 1'b1;
            core_cnt  <= 0;
            pend      <= core_calc(cor_mode, cor_x, cor_y, cor_z);
        end else if (core_busy) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == LAT - 1) begin
                core_busy <= 1'b0;
                if (!kill_done) begin
                    cor_done <= 1'b1;
                    cor_xo   <= pend.x;
                    cor_yo   <= pend.y;
                    cor_zo   <= pend.z;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int           start_cnt = 0;
    int           rstp_cnt  = 0;
    int           stab_bad  = 0;
    logic         watch     = 1'b0;
    logic [3*W:0] snap;

    always @(negedge clk) begin
        if (rst) begin
            watch <= 1'b0;
        end else if (cor_start) begin
            watch <= 1'b1;
            snap  <= {cor_mode, cor_x, cor_y, cor_z};
        end else if (watch) begin
            if ({cor_mode, cor_x, cor_y, cor_z} !== snap) stab_bad <= stab_bad + 1;
            if (bus.rsp_valid) watch <= 1'b0;
        end
        if (cor_start === 1'b1) start_cnt <= start_cnt + 1;
        if (cor_rst === 1'b1 && !rst) rstp_cnt <= rstp_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic signed [W-1:0] obs, input int exp, input int tol);
        longint d;
        if (tol >= 0) begin
            n_checks++;
            d = longint'(obs) - longint'(exp);
            assert (d <= tol && d >= -tol) else begin
                n_errs++;
                $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
            end
        end
    endtask

    function automatic exp_t mk(input int id, input logic err, input int x, y, z, input int tx, ty, tz);
        exp_t e;
        e.id = id; e.err = err; e.x = x; e.y = y; e.z = z;
        e.tx = tx; e.ty = ty; e.tz = tz;
        return e;
    endfunction

    task automatic drive_op(input int r, input logic m, input int x, y, z);
        bus.req_mode[r]       = m;
        bus.req_x[r*W +: W]   = x;
        bus.req_y[r*W +: W]   = y;
        bus.req_z[r*W +: W]   = z;
    endtask

    task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp_mask);
        logic seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (|bus.req_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_grant_seen"}, seen, 1);
        check({tag, "_grant"}, bus.req_ready, exp_mask);
    endtask

    task automatic issue(input string tag, input int r, input logic m, input int x, y, z, input exp_t e);
        drive_op(r, m, x, y, z);
        bus.req_valid[r] = 1'b1;
        #1;
        wait_grant(tag, NREQ'(1) << r);
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        check({tag, "_cor_start"}, cor_start, 1);
        check({tag, "_cor_x"}, $signed(cor_x), x);
        check({tag, "_cor_z"}, $signed(cor_z), z);
    endtask

    task automatic collect(input string tag, input logic hold_ready);
        exp_t e;
        logic seen = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_rsp_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_id"}, bus.rsp_id, e.id);
                check({tag, "_err"}, bus.rsp_err, e.err);
                check_tol({tag, "_x"}, bus.rsp_x, e.x, e.tx);
                check_tol({tag, "_y"}, bus.rsp_y, e.y, e.ty);
                check_tol({tag, "_z"}, bus.rsp_z, e.z, e.tz);
            end
            @(negedge clk);
        end
        if (!hold_ready) bus.rsp_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   n, s0, p0, bad;
        logic seen;
        logic [3*W+1:0] rsnap;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_mode  = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_z     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_id", bus.rsp_id, 0);
        check("reset_rsp_data", {bus.rsp_err, bus.rsp_x, bus.rsp_y, bus.rsp_z}, 0);
        check("reset_cor_ops", {cor_start, cor_mode, cor_x, cor_y, cor_z}, 0);
        check("reset_cor_rst", cor_rst, 1);
        rst = 1'b0;
        #1;
        check("release_cor_rst", cor_rst, 0);
        @(negedge clk);

        // Rotation of the unit vector by pi/4, then vectoring with gain-scaled magnitude.
        issue("rot", 0, 1'b0, 0, 0, 25736, mk(0, 1'b0, 23170, 23170, 0, 16, 16, -1));
        collect("rot", 1'b0);
        issue("vec", 1, 1'b1, 40960, 77005, 0, mk(1, 1'b0, 143636, 0, 35458, 64, -1, 16));
        collect("vec", 1'b0);

        // Both requesters always valid: grants must alternate starting at requester 0.
        s0 = start_cnt;
        drive_op(0, 1'b0, 0, 0, 0);
        drive_op(1, 1'b1, 32768, 0, 0);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            wait_grant("fair", NREQ'(1) << (i % 2));
            if (i % 2 == 0) sb.push_back(mk(0, 1'b0, 32768, 0, 0, 16, 16, -1));
            else            sb.push_back(mk(1, 1'b0, 53961, 0, 0, 64, -1, 16));
            @(negedge clk);
            check("fair_cor_start", cor_start, 1);
            check("fair_cor_x", $signed(cor_x), (i % 2 == 0) ? 0 : 32768);
            collect("fair", 1'b1);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        check("fair_start_count", start_cnt - s0, 6);
        check("fair_operands_stable", stab_bad, 0);

        // Core never signals done: watchdog abort after TIMEOUT busy cycles.
        kill_done = 1'b1;
        p0 = rstp_cnt;
        issue("tmo", 0, 1'b0, 0, 0, 25736, mk(0, 1'b1, 0, 0, 0, 0, 0, 0));
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("tmo_rsp_seen", seen, 1);
        check("tmo_busy_cycles", n, TIMEOUT + 1);
        check("tmo_cor_rst", cor_rst, 1);
        collect("tmo", 1'b0);
        check("tmo_cor_rst_pulses", rstp_cnt - p0, 1);
        kill_done = 1'b0;
        issue("post_tmo", 1, 1'b0, 0, 0, 25736, mk(1, 1'b0, 23170, 23170, 0, 16, 16, -1));
        collect("post_tmo", 1'b0);

        // Consumer stalls for 20 cycles while both requesters are waiting.
        issue("stall", 1, 1'b1, 40960, 77005, 0, mk(1, 1'b0, 143636, 0, 35458, 64, -1, 16));
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stall_rsp_seen", seen, 1);
        rsnap = {bus.rsp_id, bus.rsp_err, bus.rsp_x, bus.rsp_y, bus.rsp_z};
        drive_op(0, 1'b0, 0, 0, 0);
        bus.req_valid = 2'b11;
        s0  = start_cnt;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== '0 ||
                {bus.rsp_id, bus.rsp_err, bus.rsp_x, bus.rsp_y, bus.rsp_z} !== rsnap) bad++;
        end
        check("stall_held", bad, 0);
        check("stall_no_start", start_cnt - s0, 0);
        bus.req_valid = '0;
        #1;
        collect("stall", 1'b0);

        // Reset three cycles into BUSY discards the operation and rewinds the pointer.
        issue("rst", 0, 1'b0, 16384, 0, 0, mk(0, 1'b0, 26981, 0, 0, 64, 16, -1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_cor_rst", cor_rst, 1);
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_regs", {bus.rsp_id, bus.rsp_err, bus.rsp_x, bus.rsp_y, bus.rsp_z}, 0);
        check("rst_cor_ops", {cor_start, cor_mode, cor_x, cor_y, cor_z}, 0);
        check("rst_req_ready", bus.req_ready, 0);
        rst = 1'b0;
        void'(sb.pop_back());
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("rst_no_response", seen, 0);
        drive_op(0, 1'b0, 16384, 0, 0);
        drive_op(1, 1'b0, 16384, 0, 0);
        bus.req_valid = 2'b11;
        #1;
        wait_grant("rst_next", 2'b01);
        sb.push_back(mk(0, 1'b0, 26981, 0, 0, 64, 16, -1));
        @(negedge clk);
        bus.req_valid = '0;
        collect("rst_next", 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
